// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: a shared binary-to-BCD engine serving two requesters.
// Round-robin arbitration picks a requester. A double-dabble datapath then
// converts one bit per clock, and the winner gets a one-cycle done strobe.
// Optional build macro: BCD_SATURATE_EN. When it is defined, an out-of-range
// operand is clamped to all 9s. When it is undefined, the result wraps
// modulo 10^DIGITS.
module bcd_conv_arbiter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [WIDTH-1:0]      bin0,
    input  logic [WIDTH-1:0]      bin1,
    output logic                  busy,
    output logic [1:0]            done,
    output logic [4*DIGITS-1:0]   bcd_value,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

`ifdef BCD_SATURATE_EN
    localparam logic [63:0]      LIMIT_M1 = LIMIT - 64'd1;
    localparam logic [WIDTH-1:0] SAT_VAL  = LIMIT_M1[WIDTH-1:0];

    // Clamp an out-of-range operand so that it converts to all 9s.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v,
                                                  input logic over);
        return over ? SAT_VAL : v;
    endfunction
`endif

    // Double-dabble correction: add 3 to every digit that is 5 or more before the shift.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
        logic [BW-1:0] r;
        r = a;
        for (int d = 0; d < DIGITS; d++) begin
            if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0]    acc;
    logic [BW-1:0]    acc_adj;
    logic [CW-1:0]    cnt;
    logic             grant;
    logic             ovf_int;
    logic             rr;
    logic             win;
    logic [WIDTH-1:0] operand;
    logic             operand_ovf;

    // Pick the winner. On a tie, the requester not served last goes first.
    always_comb begin
        win         = (req == 2'b11) ? ~rr : req[1];
        operand     = win ? bin1 : bin0;
        operand_ovf = (64'(operand) >= LIMIT);
        acc_adj     = add3(acc);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. The SHIFT state also holds one extra cycle after the
    // last shift, so the result can be captured on entry to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 2'b00) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode for busy and the done strobe.
    always_comb begin
        busy = (state != IDLE);
        done = 2'b00;
        if (state == DONE) done = grant ? 2'b10 : 2'b01;
    end

    // Datapath: latch the operand, shift-and-add-3, capture the result, and update the rr pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
            grant     <= 1'b0;
            ovf_int   <= 1'b0;
            rr        <= 1'b1;
            bcd_value <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
`ifdef BCD_SATURATE_EN
                        sr <= saturate(operand, operand_ovf);
`else
                        sr <= operand;
`endif
                        grant   <= win;
                        ovf_int <= operand_ovf;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(WIDTH)) begin
                        bcd_value <= acc;
                        ovf       <= ovf_int;
                    end else begin
                        // The carry out of the top digit is dropped, which gives the result mod 10^DIGITS.
                        acc <= BW'({acc_adj, sr[WIDTH-1]});
                        sr  <= sr << 1;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    rr <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule
